// File: rtl/mfp_uart_transmitter_pkg.sv
// Shared definitions for the mfp UART transmitter.
// Holds the FSM state encoding, the default line parameters and the
// baud divisor helper used by the top level.
package mfp_uart_transmitter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_t;

   localparam int DEFAULT_CLK_FREQ  = 27_000_000;
   localparam int DEFAULT_BAUD_RATE = 115200;

   // Clock cycles per bit, rounded to nearest.
   function automatic int uart_div(input int clk_freq, input int baud_rate);
      return (clk_freq + baud_rate / 2) / baud_rate;
   endfunction

endpackage

// File: rtl/mfp_uart_transmitter_fifo.sv
// mfp_uart_tx_fifo: single-clock synchronous FIFO, first-word fall-through.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   push, push_data   write strobe and data; ignored while full
//   pop               read strobe; ignored while empty
//   pop_data          head entry, valid whenever empty=0
//   full, empty       occupancy flags, derived from the registered count
module mfp_uart_tx_fifo #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   // One bit wider than the pointers so full and empty are distinct.
   logic [DEPTH_LOG2:0]   count;
   logic                  do_push;
   logic                  do_pop;

   assign full     = count[DEPTH_LOG2];
   assign empty    = (count == '0);
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mfp_uart_transmitter.sv
// mfp_uart_transmitter: 8N1 UART transmitter with a byte FIFO.
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   wr_en        single-cycle write strobe; wr_data is the byte to send
//   full         FIFO holds 2^FIFO_DEPTH_LOG2 entries
//   busy         FIFO non-empty or a frame in progress (registered)
//   overflow     one-cycle pulse, the cycle after a write was dropped
//   tx           serial line, idles high, driven from a flop
module mfp_uart_transmitter
   import mfp_uart_transmitter_pkg::*;
#(
   parameter int CLK_FREQ        = DEFAULT_CLK_FREQ,
   parameter int BAUD_RATE       = DEFAULT_BAUD_RATE,
   parameter int FIFO_DEPTH_LOG2 = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   output logic       full,
   output logic       busy,
   output logic       overflow,
   output logic       tx
);

   localparam int DIV = uart_div(CLK_FREQ, BAUD_RATE);
   localparam int BCW = (DIV < 2) ? 1 : $clog2(DIV);
   localparam logic [BCW-1:0] BAUD_LAST = BCW'(DIV - 1);

   if (DIV < 2) begin : g_bad_div
      $error("mfp_uart_transmitter: baud divisor must be at least 2");
   end

   tx_state_t      state, state_n;
   logic [BCW-1:0] baud_cnt, baud_n;
   logic [2:0]     bit_cnt, bit_n;
   logic [7:0]     shreg, shreg_n;
   logic           tx_n;
   logic           pop;
   logic           empty;
   logic [7:0]     head;
   logic           baud_last;

   mfp_uart_tx_fifo #(
      .WIDTH      (8),
      .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (wr_en),
      .push_data (wr_data),
      .pop       (pop),
      .pop_data  (head),
      .full      (full),
      .empty     (empty)
   );

   assign baud_last = (baud_cnt == BAUD_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         tx       <= 1'b1;
         busy     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         state    <= state_n;
         baud_cnt <= baud_n;
         bit_cnt  <= bit_n;
         shreg    <= shreg_n;
         // Line level follows the current state one cycle later, so the
         // whole frame is shifted uniformly and tx has no input path.
         tx       <= tx_n;
         busy     <= ~empty | (state != ST_IDLE);
         // full is the pre-pop state, so a write colliding with a pop
         // while full is still dropped.
         overflow <= wr_en & full;
      end
   end

   always_comb begin
      state_n = state;
      baud_n  = baud_cnt;
      bit_n   = bit_cnt;
      shreg_n = shreg;
      pop     = 1'b0;
      tx_n    = 1'b1;
      case (state)
         ST_IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               shreg_n = head;
               baud_n  = '0;
               state_n = ST_START;
            end
         end
         ST_START: begin
            tx_n = 1'b0;
            if (baud_last) begin
               baud_n  = '0;
               bit_n   = '0;
               state_n = ST_DATA;
            end else begin
               baud_n = baud_cnt + 1'b1;
            end
         end
         ST_DATA: begin
            tx_n = shreg[0];
            if (baud_last) begin
               baud_n  = '0;
               shreg_n = {1'b0, shreg[7:1]};
               if (bit_cnt == 3'd7) state_n = ST_STOP;
               else                 bit_n   = bit_cnt + 1'b1;
            end else begin
               baud_n = baud_cnt + 1'b1;
            end
         end
         ST_STOP: begin
            tx_n = 1'b1;
            if (baud_last) begin
               baud_n = '0;
               // Chain straight into the next frame when data is waiting.
               if (!empty) begin
                  pop     = 1'b1;
                  shreg_n = head;
                  state_n = ST_START;
               end else begin
                  state_n = ST_IDLE;
               end
            end else begin
               baud_n = baud_cnt + 1'b1;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

endmodule
